// File: rtl/div_iter_pkg.sv
// Shared types for the iterative divider: FSM states and request/response bundles.
// Bundles are sized by the package-level DIV_WIDTH; the divider itself is parametrised separately.
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic                 is_signed;
        logic [DIV_WIDTH-1:0] op_a;
        logic [DIV_WIDTH-1:0] op_b;
    } div_req_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] quot;
        logic [DIV_WIDTH-1:0] rem;
    } div_resp_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, dividend} left, trial-subtract the divisor.
// Purely combinational; the quotient bit enters at the dividend LSB.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dividend_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           q_bit;

    // One extra bit so a divisor of 2^(WIDTH-1) still compares correctly.
    assign shifted = {rem, dividend[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});

    always_comb begin
        rem_next = shifted[WIDTH-1:0];
        if (q_bit) begin
            rem_next = diff[WIDTH-1:0];
        end
        dividend_next = {dividend[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned divider, one quotient bit per cycle on operand magnitudes.
// Latency WIDTH+1 cycles from accept (1 for divide-by-zero); result holds until out_ready.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_quot;
    logic             neg_rem;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             a_neg;
    logic             b_neg;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign a_neg = is_signed && op_a[WIDTH-1];
    assign b_neg = is_signed && op_b[WIDTH-1];

    // The most negative value negates to itself, which read unsigned is the right magnitude.
    assign mag_a = a_neg ? (~op_a + ONE) : op_a;
    assign mag_b = b_neg ? (~op_b + ONE) : op_b;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem          (rem_acc),
        .dividend     (dvd),
        .divisor      (dvs),
        .rem_next     (rem_nxt),
        .dividend_next(dvd_nxt)
    );

    assign quot_fix = neg_quot ? (~dvd_nxt + ONE) : dvd_nxt;
    assign rem_fix  = neg_rem  ? (~rem_nxt + ONE) : rem_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            rem_acc  <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (op_b == '0) begin
                            quot  <= '1;
                            rem   <= op_a;
                            state <= DONE;
                        end else begin
                            dvd      <= mag_a;
                            dvs      <= mag_b;
                            rem_acc  <= '0;
                            cnt      <= CW'(WIDTH);
                            neg_quot <= a_neg ^ b_neg;
                            neg_rem  <= a_neg;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_acc <= rem_nxt;
                    dvd     <= dvd_nxt;
                    cnt     <= cnt - CW'(1);
                    // Final step: register the sign-corrected result straight from the step logic.
                    if (cnt == CW'(1)) begin
                        quot  <= quot_fix;
                        rem   <= rem_fix;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Randomised and directed checks of div_iter at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_div_iter;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        is_signed;
    logic        flush;
    logic        out_ready;
    logic        sel8;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        rdy32, ov32, busy32;
    logic [31:0] q32, r32;
    logic        rdy8, ov8, busy8;
    logic [7:0]  q8, r8;

    logic        obs_rdy, obs_valid, obs_busy;
    logic [31:0] obs_quot, obs_rem;

    int errors = 0;
    int checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    div_iter #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid && !sel8),
        .in_ready (rdy32),
        .is_signed(is_signed),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .out_valid(ov32),
        .out_ready(out_ready),
        .quot     (q32),
        .rem      (r32),
        .busy     (busy32)
    );

    div_iter #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid && sel8),
        .in_ready (rdy8),
        .is_signed(is_signed),
        .op_a     (op_a[7:0]),
        .op_b     (op_b[7:0]),
        .flush    (flush),
        .out_valid(ov8),
        .out_ready(out_ready),
        .quot     (q8),
        .rem      (r8),
        .busy     (busy8)
    );

    assign obs_rdy   = sel8 ? rdy8  : rdy32;
    assign obs_valid = sel8 ? ov8   : ov32;
    assign obs_busy  = sel8 ? busy8 : busy32;
    assign obs_quot  = sel8 ? {24'b0, q8} : q32;
    assign obs_rem   = sel8 ? {24'b0, r8} : r32;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic reference: SV '/' truncates toward zero and '%' takes the dividend's sign.
    function automatic void ref_div(input int w, input bit s, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] r);
        longint mask, la, lb;
        mask = (longint'(1) << w) - 1;
        la = 0;
        lb = 0;
        la[31:0] = a;
        lb[31:0] = b;
        la = la & mask;
        lb = lb & mask;
        if (lb == 0) begin
            q = mask[31:0];
            r = la[31:0];
        end else begin
            if (s) begin
                if (la[w-1]) la = la - (longint'(1) << w);
                if (lb[w-1]) lb = lb - (longint'(1) << w);
            end
            la = la & 64'hFFFF_FFFF_FFFF_FFFF;
            q = 32'((la / lb) & mask);
            r = 32'((la % lb) & mask);
        end
    endfunction

    // Called at a negedge with the selected divider idle; returns at a negedge, divider idle again.
    task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output logic [31:0] gq, output logic [31:0] gr);
        int          w;
        int          cyc;
        logic [31:0] eq, er, wmask;
        w     = sel8 ? 8 : 32;
        wmask = sel8 ? 32'hFF : 32'hFFFF_FFFF;
        ref_div(w, s, a, b, eq, er);
        chk({tag, " in_ready"}, 64'(obs_rdy), 64'd1);
        in_valid  = 1'b1;
        is_signed = s;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        in_valid  = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        is_signed = 1'($urandom);
        chk({tag, " busy"}, 64'(obs_busy), 64'd1);
        cyc = 0;
        while (!obs_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), ((b & wmask) == 0) ? 64'd0 : 64'(w));
        chk({tag, " quot"}, 64'(obs_quot), 64'(eq));
        chk({tag, " rem"}, 64'(obs_rem), 64'(er));
        gq = obs_quot;
        gr = obs_rem;
        repeat (2) @(negedge clk);
        chk({tag, " hold valid"}, 64'(obs_valid), 64'd1);
        chk({tag, " hold quot"}, 64'(obs_quot), 64'(eq));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " consumed"}, 64'(obs_valid), 64'd0);
        chk({tag, " ready again"}, 64'(obs_rdy), 64'd1);
    endtask

    initial begin
        logic [31:0] gq, gr, a, b;
        bit          s;
        bit          saw;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        sel8      = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(negedge clk);
        chk("reset in_ready32", 64'(rdy32), 64'd1);
        chk("reset out_valid32", 64'(ov32), 64'd0);
        chk("reset busy32", 64'(busy32), 64'd0);
        chk("reset quot32", 64'(q32), 64'd0);
        chk("reset rem32", 64'(r32), 64'd0);
        chk("reset in_ready8", 64'(rdy8), 64'd1);
        chk("reset out_valid8", 64'(ov8), 64'd0);
        chk("reset quot8", 64'(q8), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op(0, 32'd100, 32'd7, "u100/7", gq, gr);
        chk("u100/7 const q", 64'(gq), 64'd14);
        chk("u100/7 const r", 64'(gr), 64'd2);
        run_op(1, 32'hFFFF_FFF9, 32'd2, "s-7/2", gq, gr);
        chk("s-7/2 const q", 64'(gq), 64'hFFFF_FFFD);
        chk("s-7/2 const r", 64'(gr), 64'hFFFF_FFFF);
        run_op(1, 32'd7, 32'hFFFF_FFFE, "s7/-2", gq, gr);
        chk("s7/-2 const q", 64'(gq), 64'hFFFF_FFFD);
        chk("s7/-2 const r", 64'(gr), 64'd1);
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, "sovf", gq, gr);
        chk("sovf const q", 64'(gq), 64'h8000_0000);
        chk("sovf const r", 64'(gr), 64'd0);
        run_op(0, 32'hFFFF_FFFF, 32'h8000_0000, "ubig", gq, gr);
        chk("ubig const q", 64'(gq), 64'd1);
        chk("ubig const r", 64'(gr), 64'h7FFF_FFFF);
        run_op(0, 32'd5, 32'd0, "div0", gq, gr);
        chk("div0 const q", 64'(gq), 64'hFFFF_FFFF);
        chk("div0 const r", 64'(gr), 64'd5);
        run_op(1, 32'hFFFF_FFFB, 32'd0, "sdiv0", gq, gr);

        // Flush in the middle of a calculation.
        in_valid = 1'b1;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush out_valid", 64'(ov32), 64'd0);
        chk("flush busy", 64'(busy32), 64'd0);
        chk("flush in_ready", 64'(rdy32), 64'd1);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ov32 || busy32) saw = 1'b1;
        end
        chk("flush no result", 64'(saw), 64'd0);

        // Flush together with an offer: nothing accepted.
        flush    = 1'b1;
        in_valid = 1'b1;
        op_b     = 32'd3;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush+valid busy", 64'(busy32), 64'd0);
        @(negedge clk);
        chk("flush+valid idle", 64'(busy32 || ov32), 64'd0);

        // Reset mid-calculation (previous result registers are non-zero here).
        in_valid = 1'b1;
        op_a     = 32'd12345;
        op_b     = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("rst mid quot", 64'(q32), 64'd0);
        chk("rst mid rem", 64'(r32), 64'd0);
        chk("rst mid out_valid", 64'(ov32), 64'd0);
        chk("rst mid busy", 64'(busy32), 64'd0);

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = 32'h8000_0000;
                4:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op(s, a, b, "rand32", gq, gr);
        end

        // WIDTH=8: the first two run back to back.
        sel8 = 1'b1;
        run_op(0, 32'd200, 32'd3, "u200/3", gq, gr);
        chk("u200/3 const q", 64'(gq), 64'd66);
        chk("u200/3 const r", 64'(gr), 64'd2);
        run_op(1, 32'h80, 32'hFF, "s8ovf", gq, gr);
        chk("s8ovf const q", 64'(gq), 64'h80);
        chk("s8ovf const r", 64'(gr), 64'd0);
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            a = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFF;
                2:       b = 32'h80;
                default: b = 32'($urandom_range(0, 255));
            endcase
            run_op(s, a, b, "rand8", gq, gr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
